// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types and constants for the sweeping memory array.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_SETS  = 64;
    localparam int unsigned HPDCACHE_DIR_W = 28;

    // Counter width used for the directory set index (at least one bit).
    function automatic int unsigned hpdcache_cnt_w(input int unsigned sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    localparam int unsigned HPDCACHE_SET_W = hpdcache_cnt_w(HPDCACHE_SETS);

    typedef logic [HPDCACHE_DIR_W-1:0] hpdcache_dir_entry_t;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } hpdcache_sweep_state_e;

endpackage

// File: rtl/hpdcache_memarray_sweep_fsm.sv
// Sweep sequencer: owns ready, the set counter and the sweep/client directory mux.
module hpdcache_memarray_sweep_fsm
    import hpdcache_pkg::*;
#(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned SETS  = 64,
    parameter int unsigned DIR_W = 28,
    parameter int unsigned SET_W = hpdcache_cnt_w(SETS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  init_req_i,
    output logic                  ready_o,
    input  logic [SET_W-1:0]      dir_addr_i,
    input  logic [WAYS-1:0]       dir_cs_i,
    input  logic [WAYS-1:0]       dir_we_i,
    input  logic [WAYS*DIR_W-1:0] dir_wentry_i,
    output logic [SET_W-1:0]      sram_addr_o,
    output logic [WAYS-1:0]       sram_cs_o,
    output logic [WAYS-1:0]       sram_we_o,
    output logic [WAYS*DIR_W-1:0] sram_wentry_o
);

    hpdcache_sweep_state_e state;
    logic [SET_W-1:0]      cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= SWEEP;
            cnt     <= '0;
            ready_o <= 1'b0;
        end else begin
            case (state)
                SWEEP: begin
                    if (cnt == SET_W'(SETS - 1)) begin
                        state   <= READY;
                        cnt     <= '0;
                        ready_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    // Requests in this cycle are still serviced; sweep starts next cycle.
                    if (init_req_i) begin
                        state   <= SWEEP;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= SWEEP;
                    cnt     <= '0;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sram_addr_o   = dir_addr_i;
        sram_cs_o     = dir_cs_i & {WAYS{ready_o}};
        sram_we_o     = dir_we_i & {WAYS{ready_o}};
        sram_wentry_o = dir_wentry_i;
        if (state == SWEEP) begin
            sram_addr_o   = cnt;
            sram_cs_o     = '1;
            sram_we_o     = '1;
            sram_wentry_o = '0;
        end
    end

endmodule

// File: rtl/hpdcache_sram.sv
// Single-port SRAM model: read data holds until the next read of this macro.
module hpdcache_sram #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (cs && we) begin
            mem[addr] <= wdata;
        end else if (cs) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hpdcache_sram_wbyteenable.sv
// Single-port SRAM model with per-byte write enables for the data cuts.
module hpdcache_sram_wbyteenable #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                cs,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (cs && we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end else if (cs) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hpdcache_memarray_sweep.sv
// HPDcache directory/data array with init sweep and read-valid tracking.
// Define HPDCACHE_DIR_PARITY_EN to store and check even parity per directory entry.
module hpdcache_memarray_sweep
    import hpdcache_pkg::*;
#(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 64,
    parameter int unsigned DIR_W      = 28,
    parameter int unsigned DATA_CUTS  = 4,
    parameter int unsigned DATA_DEPTH = 256,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned SET_W      = hpdcache_cnt_w(SETS),
    parameter int unsigned DADDR_W    = hpdcache_cnt_w(DATA_DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          init_req_i,
    output logic                          ready_o,
    input  logic [SET_W-1:0]              dir_addr_i,
    input  logic [WAYS-1:0]               dir_cs_i,
    input  logic [WAYS-1:0]               dir_we_i,
    input  logic [WAYS*DIR_W-1:0]         dir_wentry_i,
    output logic [WAYS*DIR_W-1:0]         dir_rentry_o,
    output logic [WAYS-1:0]               dir_rvalid_o,
    output logic [WAYS-1:0]               dir_perr_o,
    input  logic [DATA_CUTS*DADDR_W-1:0]  data_addr_i,
    input  logic [DATA_CUTS-1:0]          data_cs_i,
    input  logic [DATA_CUTS-1:0]          data_we_i,
    input  logic [DATA_CUTS*DATA_W/8-1:0] data_be_i,
    input  logic [DATA_CUTS*DATA_W-1:0]   data_wdata_i,
    output logic [DATA_CUTS*DATA_W-1:0]   data_rdata_o,
    output logic [DATA_CUTS-1:0]          data_rvalid_o
);

    logic [SET_W-1:0]      sram_addr_p0;
    logic [WAYS-1:0]       sram_cs_p0;
    logic [WAYS-1:0]       sram_we_p0;
    logic [WAYS*DIR_W-1:0] sram_wentry_p0;
    logic [DATA_CUTS-1:0]  data_cs_p0;
    logic [DATA_CUTS-1:0]  data_we_p0;
    logic [WAYS-1:0]       vld_dir_p1;
    logic [DATA_CUTS-1:0]  vld_data_p1;

    hpdcache_memarray_sweep_fsm #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .DIR_W (DIR_W),
        .SET_W (SET_W)
    ) u_fsm (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .init_req_i    (init_req_i),
        .ready_o       (ready_o),
        .dir_addr_i    (dir_addr_i),
        .dir_cs_i      (dir_cs_i),
        .dir_we_i      (dir_we_i),
        .dir_wentry_i  (dir_wentry_i),
        .sram_addr_o   (sram_addr_p0),
        .sram_cs_o     (sram_cs_p0),
        .sram_we_o     (sram_we_p0),
        .sram_wentry_o (sram_wentry_p0)
    );

    // The data array is never swept, only blocked while not ready.
    assign data_cs_p0 = data_cs_i & {DATA_CUTS{ready_o}};
    assign data_we_p0 = data_we_i & {DATA_CUTS{ready_o}};

    // p0 -> p1: read-valid follows the SRAM read latency
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_dir_p1  <= '0;
            vld_data_p1 <= '0;
        end else begin
            vld_dir_p1  <= {WAYS{ready_o}} & dir_cs_i & ~dir_we_i;
            vld_data_p1 <= {DATA_CUTS{ready_o}} & data_cs_i & ~data_we_i;
        end
    end

    assign dir_rvalid_o  = vld_dir_p1;
    assign data_rvalid_o = vld_data_p1;

    for (genvar w = 0; w < WAYS; w++) begin : g_dir
`ifdef HPDCACHE_DIR_PARITY_EN
        logic [DIR_W:0] wentry_p0;
        logic [DIR_W:0] rentry_p1;

        // Sweep writes all-zero data, so its parity bit is naturally zero.
        assign wentry_p0 = {^sram_wentry_p0[w*DIR_W +: DIR_W], sram_wentry_p0[w*DIR_W +: DIR_W]};

        hpdcache_sram #(
            .WIDTH  (DIR_W + 1),
            .DEPTH  (SETS),
            .ADDR_W (SET_W)
        ) u_sram (
            .clk   (clk_i),
            .cs    (sram_cs_p0[w]),
            .we    (sram_we_p0[w]),
            .addr  (sram_addr_p0),
            .wdata (wentry_p0),
            .rdata (rentry_p1)
        );

        assign dir_rentry_o[w*DIR_W +: DIR_W] = rentry_p1[DIR_W-1:0];
        assign dir_perr_o[w] = vld_dir_p1[w] & (^rentry_p1);
`else
        hpdcache_sram #(
            .WIDTH  (DIR_W),
            .DEPTH  (SETS),
            .ADDR_W (SET_W)
        ) u_sram (
            .clk   (clk_i),
            .cs    (sram_cs_p0[w]),
            .we    (sram_we_p0[w]),
            .addr  (sram_addr_p0),
            .wdata (sram_wentry_p0[w*DIR_W +: DIR_W]),
            .rdata (dir_rentry_o[w*DIR_W +: DIR_W])
        );

        assign dir_perr_o[w] = 1'b0;
`endif
    end

    for (genvar c = 0; c < DATA_CUTS; c++) begin : g_data
        hpdcache_sram_wbyteenable #(
            .DATA_W (DATA_W),
            .DEPTH  (DATA_DEPTH),
            .ADDR_W (DADDR_W)
        ) u_sram (
            .clk   (clk_i),
            .cs    (data_cs_p0[c]),
            .we    (data_we_p0[c]),
            .addr  (data_addr_i[c*DADDR_W +: DADDR_W]),
            .be    (data_be_i[c*DATA_W/8 +: DATA_W/8]),
            .wdata (data_wdata_i[c*DATA_W +: DATA_W]),
            .rdata (data_rdata_o[c*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_hpdcache_memarray_sweep.sv
// Directed self-checking bench for hpdcache_memarray_sweep (default geometry).
module tb_hpdcache_memarray_sweep;

    localparam int WAYS = 4, SETS = 64, DIR_W = 28;
    localparam int CUTS = 4, DEPTH = 256, DW = 128, AW = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   init_req;
    logic                   ready;
    logic [5:0]             dir_addr;
    logic [WAYS-1:0]        dir_cs, dir_we;
    logic [WAYS*DIR_W-1:0]  dir_wentry, dir_rentry;
    logic [WAYS-1:0]        dir_rvalid, dir_perr;
    logic [CUTS*AW-1:0]     data_addr;
    logic [CUTS-1:0]        data_cs, data_we;
    logic [CUTS*DW/8-1:0]   data_be;
    logic [CUTS*DW-1:0]     data_wdata, data_rdata;
    logic [CUTS-1:0]        data_rvalid;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] pat_a;
    logic [DW-1:0] pat_b;

    always #5 clk = ~clk;

    hpdcache_memarray_sweep dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .init_req_i    (init_req),
        .ready_o       (ready),
        .dir_addr_i    (dir_addr),
        .dir_cs_i      (dir_cs),
        .dir_we_i      (dir_we),
        .dir_wentry_i  (dir_wentry),
        .dir_rentry_o  (dir_rentry),
        .dir_rvalid_o  (dir_rvalid),
        .dir_perr_o    (dir_perr),
        .data_addr_i   (data_addr),
        .data_cs_i     (data_cs),
        .data_we_i     (data_we),
        .data_be_i     (data_be),
        .data_wdata_i  (data_wdata),
        .data_rdata_o  (data_rdata),
        .data_rvalid_o (data_rvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starting at sweep cycle 0: ready low for SETS cycles, then high.
    task automatic sweep_check(input string tag, input int init_at);
        int bad;
        bad = 0;
        for (int c = 0; c < SETS; c++) begin
            if (ready !== 1'b0) bad++;
            init_req = (c == init_at);
            tick();
        end
        init_req = 1'b0;
        chk({tag, "_ready_low"}, bad, 0);
        chk({tag, "_ready_high"}, ready, 1'b1);
    endtask

    task automatic idle();
        dir_cs = '0; dir_we = '0; data_cs = '0; data_we = '0;
    endtask

    initial begin
        rst = 1'b1; init_req = 1'b0;
        dir_addr = '0; dir_cs = '0; dir_we = '0; dir_wentry = '0;
        data_addr = '0; data_cs = '0; data_we = '0; data_be = '0; data_wdata = '0;
        pat_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        pat_b = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        tick(); tick(); tick();
        chk("rst_ready", ready, 1'b0);
        chk("rst_dir_rvalid", dir_rvalid, 4'b0);
        chk("rst_data_rvalid", data_rvalid, 4'b0);
        chk("rst_perr", dir_perr, 4'b0);

        rst = 1'b0;
        sweep_check("init_sweep", -1);

        dir_cs = 4'hF; dir_addr = 6'd0; tick(); idle();
        chk("set0_rvalid", dir_rvalid, 4'hF);
        chk("set0_rentry", dir_rentry, '0);
        dir_cs = 4'hF; dir_addr = 6'd63; tick(); idle();
        chk("set63_rentry", dir_rentry, '0);

        // Write way 2 set 5, then read it back.
        dir_cs = 4'b0100; dir_we = 4'b0100; dir_addr = 6'd5;
        dir_wentry = '0; dir_wentry[2*DIR_W +: DIR_W] = 28'hABCDE01;
        tick(); idle();
        chk("wr_rvalid", dir_rvalid, 4'b0);
        dir_cs = 4'b0100; tick(); idle();
        chk("way2_rvalid", dir_rvalid, 4'b0100);
        chk("way2_rentry", dir_rentry[2*DIR_W +: DIR_W], 28'hABCDE01);
        chk("way2_perr", dir_perr, 4'b0);
        tick();
        chk("rvalid_drop", dir_rvalid, 4'b0);

        // Read way 0 and write way 1 in the same cycle.
        dir_cs = 4'b0011; dir_we = 4'b0010; dir_addr = 6'd5;
        dir_wentry = '0; dir_wentry[1*DIR_W +: DIR_W] = 28'h0000123;
        tick(); idle();
        chk("mixed_rvalid", dir_rvalid, 4'b0001);
        chk("mixed_way0", dir_rentry[0 +: DIR_W], 28'h0);
        dir_cs = 4'b0010; tick(); idle();
        chk("way1_rentry", dir_rentry[1*DIR_W +: DIR_W], 28'h0000123);

        // Data cut 1: clear, byte-masked all-ones write, read.
        data_addr = '0; data_addr[1*AW +: AW] = 8'd9;
        data_cs = 4'b0010; data_we = 4'b0010;
        data_be = '0; data_be[16 +: 16] = 16'hFFFF; data_wdata = '0;
        tick();
        data_be[16 +: 16] = 16'h00FF; data_wdata[DW +: DW] = '1;
        tick();
        data_we = '0; tick(); idle();
        chk("cut1_rvalid", data_rvalid, 4'b0010);
        chk("cut1_rdata", data_rdata[DW +: DW], {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
        data_cs = 4'b0010; data_we = 4'b0010; data_be[16 +: 16] = 16'hFFFF;
        data_wdata[DW +: DW] = pat_b;
        tick(); idle();
        chk("cut1_hold", data_rdata[DW +: DW], {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
        chk("cut1_wr_novalid", data_rvalid, 4'b0);

        // Cut 0 addr 3 holds pat_a across a re-sweep.
        data_addr = '0; data_addr[0 +: AW] = 8'd3;
        data_cs = 4'b0001; data_we = 4'b0001; data_be = '0; data_be[0 +: 16] = 16'hFFFF;
        data_wdata = '0; data_wdata[0 +: DW] = pat_a;
        tick(); idle();

        // Re-sweep: pulse at t, blocked accesses at t+3 and t+4.
        init_req = 1'b1; tick(); init_req = 1'b0;
        chk("resweep_ready_t1", ready, 1'b0);
        tick(); tick();
        dir_cs = 4'hF; dir_addr = 6'd5;
        data_cs = 4'b0001; data_we = 4'b0001; data_wdata[0 +: DW] = pat_b;
        tick(); idle();
        chk("sweep_dir_dropped", dir_rvalid, 4'b0);
        data_cs = 4'b0001; tick(); idle();
        chk("sweep_data_dropped", data_rvalid, 4'b0);
        // Now at t+5; ready rises at t+65. A second init_req lands mid-sweep.
        for (int i = 0; i < 59; i++) begin
            init_req = (i == 5);
            tick();
        end
        init_req = 1'b0;
        chk("resweep_ready_t64", ready, 1'b0);
        tick();
        chk("resweep_ready_t65", ready, 1'b1);

        dir_cs = 4'hF; dir_addr = 6'd5; tick(); idle();
        chk("cleared_rvalid", dir_rvalid, 4'hF);
        chk("cleared_rentry", dir_rentry, '0);
        data_cs = 4'b0001; tick(); idle();
        chk("cut0_kept_rvalid", data_rvalid, 4'b0001);
        chk("cut0_kept", data_rdata[0 +: DW], pat_a);

        // Reset asserted 30 cycles into a sweep.
        init_req = 1'b1; tick(); init_req = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        rst = 1'b1; tick();
        chk("midrst_ready", ready, 1'b0);
        tick(); rst = 1'b0;
        sweep_check("restart_sweep", 10);
        tick();
        chk("restart_ready_stays", ready, 1'b1);

`ifdef HPDCACHE_DIR_PARITY_EN
        dir_cs = 4'b0001; dir_we = 4'b0001; dir_addr = 6'd7;
        dir_wentry = '0; dir_wentry[0 +: DIR_W] = 28'h0000003;
        tick(); idle();
        dut.g_dir[0].u_sram.mem[7][0] = 1'b0;
        dir_cs = 4'b0001; tick(); idle();
        chk("perr_rvalid", dir_rvalid, 4'b0001);
        chk("perr_set", dir_perr, 4'b0001);
        tick();
        chk("perr_pulse", dir_perr, 4'b0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
